psg_reg_writer: RTL and testbench

- Host-side transmitter for the PSG's two-phase register-write bus.
- The receiver toggles an internal phase flag every clock from reset. On odd cycles it latches bus[3:0] as the register address; on even cycles it writes the bus byte into the latched register.
- This block queues register writes from a local client through a small FIFO. It serialises each write onto the 8-bit bus in lock-step with the receiver's phase.
- Between writes it drives a no-op address, so the receiver's unconditional data-phase writes never corrupt live registers.
- It sits between the control source (sequencer or host interface) and the PSG's ui_in, with both reset together.

---
 rtl/psg_reg_writer.sv | 96 +++++++++
 tb/tb_psg_reg_writer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/psg_reg_writer.sv
// Host-side transmitter for the PSG two-phase register-write bus: queues client writes in a
// small FIFO and serialises them as address/data byte pairs in lock-step with the receiver phase.
module psg_reg_writer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned IDLE_ADDR  = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_wr_valid,
  output logic                          o_wr_ready,
  input  logic [3:0]                    i_wr_addr,
  input  logic [7:0]                    i_wr_data,
  output logic [7:0]                    o_bus_out,
  output logic                          o_bus_addr_phase,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_idle
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [3:0]      r_mem_addr [FIFO_DEPTH];
  logic [7:0]      r_mem_data [FIFO_DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic            r_phase;
  logic            r_inflight;
  logic [7:0]      r_hold;
  logic [7:0]      r_bus;

  logic            w_push;
  logic            w_pop;
  logic [CntW-1:0] w_count_nxt;
  logic [7:0]      w_bus_nxt;
  logic [7:0]      w_hold_nxt;
  logic            w_inflight_nxt;

  // Pop only on address-phase edges and only from pre-edge contents, so a push never bypasses.
  assign w_push = i_wr_valid && o_wr_ready;
  assign w_pop  = !r_phase && (r_count != '0);

  always_comb begin
    w_count_nxt    = r_count + CntW'(w_push) - CntW'(w_pop);
    w_bus_nxt      = r_bus;
    w_hold_nxt     = r_hold;
    w_inflight_nxt = r_inflight;
    if (!r_phase) begin
      if (w_pop) begin
        w_bus_nxt      = {4'h0, r_mem_addr[r_rd_ptr]};
        w_hold_nxt     = r_mem_data[r_rd_ptr];
        w_inflight_nxt = 1'b1;
      end else begin
        w_bus_nxt      = {4'h0, 4'(IDLE_ADDR)};
        w_inflight_nxt = 1'b0;
      end
    end else begin
      // Undecoded address was latched when nothing is in flight, so the zero write is a no-op.
      w_bus_nxt = r_inflight ? r_hold : 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_phase    <= 1'b0;
      r_inflight <= 1'b0;
      r_hold     <= 8'h00;
      r_bus      <= 8'h00;
    end else begin
      r_phase    <= !r_phase;
      r_count    <= w_count_nxt;
      r_bus      <= w_bus_nxt;
      r_hold     <= w_hold_nxt;
      r_inflight <= w_inflight_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem_addr[r_wr_ptr] <= i_wr_addr;
      r_mem_data[r_wr_ptr] <= i_wr_data;
    end
  end

  assign o_wr_ready       = (r_count != CntW'(FIFO_DEPTH));
  assign o_bus_out        = r_bus;
  assign o_bus_addr_phase = r_phase;
  assign o_fifo_level     = r_count;
  assign o_idle           = (r_count == '0) && !r_inflight;

endmodule

// File: tb/tb_psg_reg_writer.sv
// Randomised and directed bench for psg_reg_writer, checked every cycle against a transaction-level
// model (write queue plus alternating bus slots) and a model of the PSG register-file receiver.
module tb_psg_reg_writer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned IDLE  = 15;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [3:0] addr;
  logic [7:0] data;
  logic       ready;
  logic [7:0] bus;
  logic       aph;
  logic [2:0] level;
  logic       idle;

  psg_reg_writer #(
    .FIFO_DEPTH(DEPTH),
    .IDLE_ADDR (IDLE)
  ) dut (
    .clk             (clk),
    .reset           (rst),
    .i_wr_valid      (valid),
    .o_wr_ready      (ready),
    .i_wr_addr       (addr),
    .i_wr_data       (data),
    .o_bus_out       (bus),
    .o_bus_addr_phase(aph),
    .o_fifo_level    (level),
    .o_idle          (idle)
  );

  always #5 clk = ~clk;

  // Transaction model
  wr_t      q[$];
  bit       m_phase;
  bit       m_busy;
  bit       m_acc;
  logic [7:0] m_bus;
  logic [7:0] m_hold;
  logic [7:0] shadow[16];

  // Receiver model
  bit       rx_flag;
  logic [3:0] rx_latch;
  logic [7:0] rx_reg[16];

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    int  n;
    wr_t h;
    logic [13:0] exp_v;
    @(posedge clk);
    n     = q.size();
    m_acc = 1'b0;
    if (rst) begin
      q.delete();
      m_phase = 1'b0;
      m_bus   = 8'h00;
      m_busy  = 1'b0;
      m_hold  = 8'h00;
      for (int i = 0; i < 16; i++) shadow[i] = 8'h00;
    end else begin
      m_acc = valid && (n < DEPTH);
      if (!m_phase) begin
        if (n > 0) begin
          h      = q.pop_front();
          m_bus  = {4'h0, h.a};
          m_hold = h.d;
          m_busy = 1'b1;
        end else begin
          m_bus  = 8'(IDLE);
          m_busy = 1'b0;
        end
      end else begin
        m_bus = m_busy ? m_hold : 8'h00;
      end
      if (m_acc) begin
        q.push_back('{a: addr, d: data});
        shadow[addr] = data;
      end
      m_phase = !m_phase;
    end
    #1;
    exp_v = {m_bus, m_phase, 3'(q.size()), (q.size() == 0) && !m_busy, q.size() < DEPTH};
    check("outputs{bus,phase,level,idle,ready}", {bus, aph, level, idle, ready}, exp_v);
    if (rst) begin
      rx_flag  = 1'b0;
      rx_latch = 4'h0;
      for (int i = 0; i < 16; i++) rx_reg[i] = 8'h00;
    end
    if (rx_flag) rx_latch = bus[3:0];
    else rx_reg[rx_latch] = bus;
    rx_flag = !rx_flag;
  endtask

  task automatic push(input logic [3:0] a, input logic [7:0] d, output int stalls);
    int k = 0;
    stalls = 0;
    valid  = 1'b1;
    addr   = a;
    data   = d;
    step();
    while (!m_acc && k < 20) begin
      stalls++;
      k++;
      step();
    end
    if (!m_acc) check("push_timeout", 0, 1);
  endtask

  task automatic drain();
    int k = 0;
    valid = 1'b0;
    while (!(q.size() == 0 && !m_busy) && k < 60) begin
      step();
      k++;
    end
    check("drain_done", (q.size() == 0 && !m_busy), 1);
    step();
    step();
  endtask

  initial begin
    int st;
    int total_st;
    int nz;
    int acc;
    int cyc;
    rst   = 1'b1;
    valid = 1'b0;
    addr  = '0;
    data  = '0;
    step();
    step();
    check("reset_bus", bus, 8'h00);
    check("reset_state{phase,level,idle,ready}", {aph, level, idle, ready}, {1'b0, 3'd0, 1'b1, 1'b1});
    rst = 1'b0;

    // Idle pattern
    for (int i = 0; i < 8; i++) begin
      step();
      check("idle_bus", bus, (i % 2 == 0) ? 8'h0F : 8'h00);
    end

    // Single write issued on a phase==1 edge
    step();
    push(4'd7, 8'h2A, st);
    valid = 1'b0;
    check("single_gap", {aph, bus}, {1'b0, 8'h00});
    step();
    check("single_addr", {aph, bus}, {1'b1, 8'h07});
    step();
    check("single_data", {aph, bus}, {1'b0, 8'h2A});
    step();
    check("single_after", bus, 8'h0F);
    step();
    check("rx_reg7", rx_reg[7], 8'h2A);
    nz = 0;
    for (int i = 0; i < 14; i++) if (i != 7 && rx_reg[i] != 8'h00) nz++;
    check("rx_others_untouched", nz, 0);

    // Five back-to-back writes
    for (int i = 0; i < 5; i++) push(4'(i), 8'h10 + 8'(i), st);
    drain();
    for (int i = 0; i < 5; i++) check("burst_reg", rx_reg[i], 8'h10 + 8'(i));

    // Twelve writes with valid held: fills the FIFO, stalls, wraps pointers
    total_st = 0;
    for (int i = 0; i < 12; i++) begin
      push(4'(i), 8'hA0 + 8'(i), st);
      total_st += st;
    end
    drain();
    check("full_stalled", total_st > 0, 1);
    for (int i = 0; i < 12; i++) check("wrap_reg", rx_reg[i], 8'hA0 + 8'(i));

    // Reset while an address byte for register 3 is on the bus
    push(4'd3, 8'h55, st);
    valid = 1'b0;
    cyc = 0;
    while (!(bus == 8'h03 && aph) && cyc < 10) begin
      step();
      cyc++;
    end
    check("saw_addr3", {aph, bus}, {1'b1, 8'h03});
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midreset_state{bus,phase,level,idle}", {bus, aph, level, idle},
          {8'h00, 1'b0, 3'd0, 1'b1});
    for (int i = 0; i < 6; i++) step();
    check("midreset_reg3", rx_reg[3], 8'h00);

    // Random traffic
    acc = 0;
    cyc = 0;
    while (acc < 100 && cyc < 3000) begin
      valid = ($urandom_range(0, 3) != 0);
      addr  = 4'($urandom_range(0, 15));
      data  = 8'($urandom);
      step();
      if (m_acc) acc++;
      cyc++;
    end
    check("random_accepts", acc, 100);
    drain();
    for (int i = 0; i < 14; i++) check("random_reg", rx_reg[i], shadow[i]);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
